rv_skid_fifo: RTL and testbench
===============================

// Module: rv_skid_fifo
// PURPOSE
//  Parametrised successor to the single-entry skid buffer: a DEPTH-entry ready/valid elastic buffer.
//  Breaks both valid/data and ready timing paths.
//  Sits between any two rv_if-style producer/consumer stages.
//  Adds a fill level, an almost-full flag and an optional empty-bypass path.
// PARAMETERS
//  DATA_WIDTH    8   payload width in bits, >=1
//  DEPTH         4   entries, power of two, >=2
//  AFULL_THRESH  3   almost_full asserts when level >= AFULL_THRESH, 1..DEPTH
// PORTS
//  clk          in   1                      system clock, rising edge
//  rst          in   1                      asynchronous, active-high reset
//  s_valid      in   1                      upstream valid
//  s_ready      out  1                      upstream ready, registered
//  s_data       in   DATA_WIDTH             upstream payload
//  m_valid      out  1                      downstream valid
//  m_ready      in   1                      downstream ready
//  m_data       out  DATA_WIDTH             downstream payload
//  level        out  $clog2(DEPTH+1)        current occupancy, 0..DEPTH
//  almost_full  out  1                      level >= AFULL_THRESH, registered
// BEHAVIOUR
//  - Reset: asynchronous, active-high, one clock.
//  - Values while rst is high: s_ready=0, m_valid=0, m_data=0, level=0, almost_full=0, pointers=0.
//  - First clk edge after rst falls: s_ready=1.
//  - Handshake:
//    - push = s_valid & s_ready.
//    - pop = m_valid & m_ready.
//    - Transfers occur only on the rising edge of clk.
//  - Producer rules: s_data is ignored unless push. The producer may drop s_valid without a handshake.
//  - Output stability: m_valid/m_data are held stable while m_valid & !m_ready.
//  - s_ready is a flop, next value (level_next != DEPTH). No combinational path m_ready -> s_ready.
//  - Storage: circular array indexed by wr_ptr/rd_ptr, each $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0.
//  - m_data is taken from a registered head.
//  - Latency: accept at edge N -> m_valid=1 after edge N (not bypass build). Throughput 1 word/clk.
//  - Occupancy: level_next = level + push - pop.
//  - Push and pop in the same cycle: level unchanged, both pointers advance.
//  - Full (level==DEPTH):
//    - s_ready=0, no push.
//    - A pop while full: s_ready=1 after that edge, not in the same cycle.
//  - Empty (level==0): m_valid=0. A push while empty: m_valid=1 after that edge.
//  - Ordering: strict FIFO order, no drop, no duplication.
//  - Reset mid-transfer: all contents discarded, all outputs forced to reset values immediately.
//  - almost_full is computed from level_next and registered.
// CONFIGURATION
//  RV_SKID_FIFO_BYPASS_EN defined:
//    - When level==0 and s_valid & m_ready: s_data passes to m_data combinationally, same cycle, not stored.
//    - In that case m_valid = s_valid, and level stays 0.
//    - When level==0 and !m_ready: the word is stored as normal.
//    - s_ready remains registered.
//  RV_SKID_FIFO_BYPASS_EN undefined:
//    - No combinational path s_* -> m_*.
//    - Minimum latency is 1 clk.
// STRUCTURE
//  - Package rv_pkg holds:
//    - function clog2_min1(n): pointer width, min 1.
//    - typedef rv_level_t helper.
//    - The shared localparam for the rv_if payload default width (8).
//  - Sub-module rv_skid_fifo_mem:
//    - DEPTH x DATA_WIDTH register array.
//    - 1 write port, 1 registered read port with read-enable.
//    - No reset on the array.
//  - Top level: pointers, level counter, flag flops, bypass mux.
// TESTING
//  - Reset: hold rst 20 ns.
//    -> Outputs at reset values during rst.
//    -> s_ready=1 one edge after release.
//  - Fill: DEPTH=4, m_ready=0, push 0x01..0x05 every clk.
//    -> 0x01..0x04 accepted, level 1,2,3,4.
//    -> almost_full=1 once level reaches 3.
//    -> s_ready=0 at level 4, 0x05 held by producer.
//  - Drain: from full, m_ready=1.
//    -> 0x01,0x02,0x03,0x04 out on consecutive clks.
//    -> s_ready=1 one edge after the first pop.
//    -> m_valid=0 after the fourth pop.
//  - Streaming: s_valid=1, m_ready=1, incrementing data 0x00..0xFF.
//    -> 1 word/clk, level steady at 1 (0 in bypass build), in-order, 8-bit wrap 0xFF->0x00 seen.
//  - Random backpressure: m_ready random 50%, s_valid random 70%, 1000 words.
//    -> Scoreboard matches order.
//    -> m_data stable while stalled.
//    -> level never exceeds 4.
//  - Reset mid-operation: assert rst with level=3.
//    -> m_valid=0, level=0 immediately.
//    -> Old words never appear after release.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared ready/valid helpers: pointer-width function, default payload width, level type.
package rv_pkg;

   localparam int unsigned RV_DATA_W    = 8;
   localparam int unsigned RV_DEPTH_DEF = 4;

   // Pointer width for a circular buffer; never narrower than one bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   typedef logic [$clog2(RV_DEPTH_DEF+1)-1:0] rv_level_t;

endpackage

// File: rtl/rv_skid_fifo_mem.sv
// DEPTH x DATA_WIDTH storage with one write port and one registered, enabled read port.
// A read of the address being written in the same cycle returns the new word.
module rv_skid_fifo_mem
   import rv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = RV_DATA_W,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned AW         = clog2_min1(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [AW-1:0]         rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
      end
   end

endmodule

// File: rtl/rv_skid_fifo.sv
// DEPTH-entry ready/valid elastic buffer with registered s_ready, level and almost_full.
// Define RV_SKID_FIFO_BYPASS_EN for a same-cycle s_data -> m_data path when empty.
module rv_skid_fifo
   import rv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = RV_DATA_W,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned AFULL_THRESH = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [DATA_WIDTH-1:0]        s_data,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [DATA_WIDTH-1:0]        m_data,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         almost_full
);

   localparam int unsigned AW = clog2_min1(DEPTH);
   localparam int unsigned LW = $clog2(DEPTH+1);

   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic                  m_valid_q;
   logic [DATA_WIDTH-1:0] head_q;

   logic                  push_c;
   logic                  pop_c;
   logic                  bypass_c;
   logic                  store_c;
   logic                  rd_en_c;
   logic [AW-1:0]         rd_addr_c;
   logic [LW-1:0]         level_next_c;

   assign push_c = s_valid & s_ready;
   assign pop_c  = m_valid_q & m_ready;

`ifdef RV_SKID_FIFO_BYPASS_EN
   // Empty buffer and a willing consumer: hand the word straight through.
   assign bypass_c = (level == '0) & push_c & m_ready;
   assign m_valid  = m_valid_q | bypass_c;
   assign m_data   = bypass_c ? s_data : head_q;
`else
   assign bypass_c = 1'b0;
   assign m_valid  = m_valid_q;
   assign m_data   = head_q;
`endif

   assign store_c      = push_c & ~bypass_c;
   assign level_next_c = level + LW'(store_c) - LW'(pop_c);

   // Head register follows rd_ptr; reload it on a pop or when the first word lands.
   assign rd_addr_c = rd_ptr + AW'(pop_c);
   assign rd_en_c   = (level_next_c != '0) & (pop_c | (level == '0));

   rv_skid_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (AW)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (store_c),
      .wr_addr (wr_ptr),
      .wr_data (s_data),
      .rd_en   (rd_en_c),
      .rd_addr (rd_addr_c),
      .rd_data (head_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         m_valid_q   <= 1'b0;
         s_ready     <= 1'b0;
         almost_full <= 1'b0;
      end else begin
         if (store_c) wr_ptr <= wr_ptr + AW'(1);
         if (pop_c)   rd_ptr <= rd_ptr + AW'(1);
         level       <= level_next_c;
         m_valid_q   <= (level_next_c != '0);
         s_ready     <= (level_next_c != LW'(DEPTH));
         almost_full <= (level_next_c >= LW'(AFULL_THRESH));
      end
   end

endmodule

// File: tb/tb_rv_skid_fifo.sv
// Directed and random-backpressure bench for rv_skid_fifo (DEPTH=4, 8-bit data).
module tb_rv_skid_fifo;

   logic       clk;
   logic       rst;
   logic       s_valid;
   logic       s_ready;
   logic [7:0] s_data;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] m_data;
   logic [2:0] level;
   logic       almost_full;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] q[$];
   logic       stall_prev;
   logic [7:0] held;
   logic       last_push;
   int         n_out;
   logic [7:0] prev_out;
   logic       wrap_seen;

   rv_skid_fifo #(.DATA_WIDTH(8), .DEPTH(4), .AFULL_THRESH(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .level       (level),
      .almost_full (almost_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock of scoreboarded traffic; entered and left at posedge+1.
   task automatic step(input logic v, input logic [7:0] d, input logic r);
      logic [7:0] exp;
      s_valid = v;
      s_data  = d;
      m_ready = r;
      #1;
      if (stall_prev) begin
         check("stall_valid", 32'(m_valid), 32'd1);
         check("stall_data", 32'(m_data), 32'(held));
      end
      last_push = s_valid & s_ready;
      if (last_push) q.push_back(d);
      if (m_valid & m_ready) begin
         exp = q.pop_front();
         check("order", 32'(m_data), 32'(exp));
         if (n_out > 0 && prev_out == 8'hFF && m_data == 8'h00) wrap_seen = 1'b1;
         prev_out = m_data;
         n_out++;
      end
      stall_prev = m_valid & ~m_ready;
      held       = m_data;
      @(posedge clk); #1;
      check("level", 32'(level), 32'(q.size()));
   endtask

   initial begin
      int cyc;
      int n_pushed;
      logic [7:0] next_word;
      logic v, r;

      rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
      stall_prev = 1'b0; held = '0; last_push = 1'b0;
      n_out = 0; prev_out = '0; wrap_seen = 1'b0;

      // Reset values while rst high, then s_ready one edge after release.
      #12;
      check("rst_s_ready", 32'(s_ready), 32'd0);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_afull", 32'(almost_full), 32'd0);
      #8 rst = 1'b0;
      @(posedge clk); #1;
      check("rel_s_ready", 32'(s_ready), 32'd1);
      check("rel_level", 32'(level), 32'd0);

      // Fill with consumer stalled.
      for (int k = 1; k <= 4; k++) begin
         s_valid = 1'b1; s_data = 8'(k);
         @(posedge clk); #1;
         check("fill_level", 32'(level), 32'(k));
         check("fill_afull", 32'(almost_full), (k >= 3) ? 32'd1 : 32'd0);
         check("fill_s_ready", 32'(s_ready), (k != 4) ? 32'd1 : 32'd0);
         check("fill_m_valid", 32'(m_valid), 32'd1);
         check("fill_head", 32'(m_data), 32'h01);
      end
      s_data = 8'h05;
      @(posedge clk); #1;
      check("full_level", 32'(level), 32'd4);
      check("full_s_ready", 32'(s_ready), 32'd0);

      // Drain from full.
      s_valid = 1'b0; m_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         check("drain_valid", 32'(m_valid), 32'd1);
         check("drain_data", 32'(m_data), 32'(k));
         @(posedge clk); #1;
         check("drain_level", 32'(level), 32'(4 - k));
         check("drain_s_ready", 32'(s_ready), 32'd1);
         check("drain_afull", 32'(almost_full), (4 - k >= 3) ? 32'd1 : 32'd0);
      end
      check("drain_empty", 32'(m_valid), 32'd0);

      // Streaming at full rate across the 8-bit wrap.
      stall_prev = 1'b0; n_out = 0;
      for (int i = 0; i < 300; i++) step(1'b1, 8'(i), 1'b1);
`ifdef RV_SKID_FIFO_BYPASS_EN
      check("stream_count", 32'(n_out), 32'd300);
      check("stream_level", 32'(level), 32'd0);
`else
      check("stream_count", 32'(n_out), 32'd299);
      check("stream_level", 32'(level), 32'd1);
`endif
      check("stream_wrap", 32'(wrap_seen), 32'd1);
      cyc = 0;
      while (q.size() != 0 && cyc < 20) begin step(1'b0, 8'h00, 1'b1); cyc++; end
      check("stream_flush", 32'(q.size()), 32'd0);

      // Random backpressure, 1000 words.
      n_pushed = 0; next_word = 8'h00; cyc = 0;
      while (n_pushed < 1000 && cyc < 20000) begin
         v = ($urandom_range(0, 99) < 70);
         r = ($urandom_range(0, 99) < 50);
         step(v, v ? next_word : 8'($urandom), r);
         if (last_push) begin next_word = next_word + 8'd1; n_pushed++; end
         check("rand_level_max", 32'(level <= 3'd4), 32'd1);
         cyc++;
      end
      check("rand_pushed", 32'(n_pushed), 32'd1000);
      cyc = 0;
      while (q.size() != 0 && cyc < 50) begin step(1'b0, 8'h00, 1'b1); cyc++; end
      check("rand_flush", 32'(q.size()), 32'd0);
      check("rand_level0", 32'(level), 32'd0);

      // Reset mid-operation with three words queued.
      stall_prev = 1'b0;
      s_valid = 1'b1; m_ready = 1'b0;
      s_data = 8'h11; @(posedge clk); #1;
      s_data = 8'h22; @(posedge clk); #1;
      s_data = 8'h33; @(posedge clk); #1;
      check("mid_level3", 32'(level), 32'd3);
      rst = 1'b1; s_valid = 1'b0;
      #1;
      check("mid_m_valid", 32'(m_valid), 32'd0);
      check("mid_level", 32'(level), 32'd0);
      check("mid_s_ready", 32'(s_ready), 32'd0);
      check("mid_afull", 32'(almost_full), 32'd0);
      @(posedge clk); #3 rst = 1'b0;
      @(posedge clk); #1;
      check("mid_rel_s_ready", 32'(s_ready), 32'd1);
      check("mid_rel_m_valid", 32'(m_valid), 32'd0);
      s_valid = 1'b1; s_data = 8'hA5;
      @(posedge clk); #1;
      s_valid = 1'b0;
      check("post_m_valid", 32'(m_valid), 32'd1);
      check("post_m_data", 32'(m_data), 32'hA5);
      check("post_level", 32'(level), 32'd1);
      m_ready = 1'b1;
      @(posedge clk); #1;
      check("post_empty", 32'(m_valid), 32'd0);
      check("post_level0", 32'(level), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
